// File: rtl/reg_file_cfg_if.sv
// Controller-side bus of the configuration register file:
// request/response signals plus the exported configuration words.
interface reg_file_cfg_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_EXPORT = 4
);
  logic                             WrEn;
  logic                             RdEn;
  logic [ADDR_WIDTH-1:0]            Address;
  logic [DATA_WIDTH-1:0]            WrData;
  logic [DATA_WIDTH-1:0]            RdData;
  logic                             RdData_Valid;
  logic                             RdErr;
  logic                             WrErr;
  logic [NUM_EXPORT*DATA_WIDTH-1:0] Cfg_Out;
  logic [NUM_EXPORT-1:0]            Cfg_Updated;

  modport master (
    output WrEn, RdEn, Address, WrData,
    input  RdData, RdData_Valid, RdErr, WrErr,
    input  Cfg_Out, Cfg_Updated
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData,
    output RdData, RdData_Valid, RdErr, WrErr,
    output Cfg_Out, Cfg_Updated
  );
endinterface

// File: rtl/reg_file_cfg.sv
// Parametrised configuration register file with write-through read,
// per-register write protection and change-notify on exported words.
module reg_file_cfg #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_EXPORT = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VALS =
    (DEPTH*DATA_WIDTH)'(32'h2081_0000),
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input logic           CLK,
  input logic           RST,
  reg_file_cfg_if.slave bus
);

  localparam int NADDR = 2**ADDR_WIDTH;

  if (NUM_EXPORT > DEPTH) begin : g_bad_export
    $error("reg_file_cfg: NUM_EXPORT must not exceed DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NADDR-1:0]      ro_full;
  logic                  in_range;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_cur;

  assign ro_full  = NADDR'(RO_MASK);
  assign in_range = 32'(bus.Address) < DEPTH;
  assign wr_ok    = bus.WrEn && in_range && !ro_full[bus.Address];

  always_comb begin
    rd_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.Address == ADDR_WIDTH'(i)) rd_cur = mem[i];
    end
  end

  always_comb begin
    bus.Cfg_Out = '0;
    for (int i = 0; i < NUM_EXPORT; i++) begin
      bus.Cfg_Out[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.Address == ADDR_WIDTH'(i)) mem[i] <= bus.WrData;
      end
    end
  end

  // Only a value change on an exported register raises a notify pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.Cfg_Updated <= '0;
    end else begin
      for (int i = 0; i < NUM_EXPORT; i++) begin
        bus.Cfg_Updated[i] <= wr_ok
          && (bus.Address == ADDR_WIDTH'(i))
          && (bus.WrData != mem[i]);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.RdData       <= '0;
      bus.RdData_Valid <= 1'b0;
      bus.RdErr        <= 1'b0;
      bus.WrErr        <= 1'b0;
    end else begin
      bus.WrErr <= bus.WrEn && !wr_ok;
      if (bus.RdEn) begin
        bus.RdData_Valid <= 1'b1;
        bus.RdErr        <= !in_range;
        if (wr_ok)         bus.RdData <= bus.WrData;
        else if (in_range) bus.RdData <= rd_cur;
        else               bus.RdData <= '0;
      end else begin
        bus.RdData_Valid <= 1'b0;
        bus.RdErr        <= 1'b0;
      end
    end
  end

endmodule

// File: doc/reg_file_cfg.md
# reg_file_cfg

Parametrised register file that succeeds the fixed 8x16 configuration register block. It keeps single-address write/read access from the system controller and adds three things: concurrent read and write in the same cycle with write-through bypass, per-register write protection and error flags, and per-register change-notify pulses on the exported configuration registers. It sits between the system control FSM and the datapath blocks (UART, ALU, clock dividers) that consume the exported configuration words.

## Interface
- ADDR_WIDTH, 4, address width.
- DATA_WIDTH, 8, word width.
- DEPTH, 16, number of implemented registers (DEPTH <= 2^ADDR_WIDTH).
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven out on Cfg_Out.
- RST_VALS, {DEPTH*DATA_WIDTH} with reg2=8'h81, reg3=8'h20, rest 0; flattened reset values, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- RO_MASK, DEPTH'b0, bit i set makes register i read-only.

- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- WrEn  in  1  write request.
- RdEn  in  1  read request.
- Address  in  ADDR_WIDTH  shared address for read and write.
- WrData  in  DATA_WIDTH  write data.
- RdData  out  DATA_WIDTH  registered read data.
- RdData_Valid  out  1  one-cycle pulse, RdData valid.
- RdErr  out  1  one-cycle pulse, read of unimplemented address.
- WrErr  out  1  one-cycle pulse, write to unimplemented or read-only address.
- Cfg_Out  out  NUM_EXPORT*DATA_WIDTH  live contents of registers 0..NUM_EXPORT-1.
- Cfg_Updated  out  NUM_EXPORT  bit i pulses when exported register i changes value.

## Operation
- Reset (asynchronous): storage[i] <= RST_VALS slice i. RdData=0, RdData_Valid=0, RdErr=0, WrErr=0, Cfg_Updated=0. Cfg_Out shows the RST_VALS slices immediately.
- The write is legal when Address < DEPTH and RO_MASK[Address]=0. A legal write stores WrData at the clock edge.
- An illegal write leaves storage unchanged and pulses WrErr for one cycle.
- A read with Address < DEPTH gives RdData <= storage[Address] and RdData_Valid <= 1.
- A read with Address >= DEPTH gives RdData <= 0, RdData_Valid <= 1 and RdErr <= 1.
- WrEn and RdEn together are both served, since they share one address:
  - Legal write: RdData = WrData (write-through bypass).
  - Illegal write: RdData = current storage value, or 0 if unimplemented.
  - Error flags follow the per-operation rules above.
- No request in a cycle: RdData holds its value; RdData_Valid, RdErr and WrErr go to 0.
- Change detect: a legal write to register i < NUM_EXPORT with WrData != storage[i] sets Cfg_Updated[i] for exactly one cycle. Rewriting the same value gives no pulse.
- At most one Cfg_Updated bit is set per cycle.
- NUM_EXPORT > DEPTH is a parameter error; flag it with an elaboration-time check.

## Timing
- All outputs except Cfg_Out are registered.
- Read latency 1: RdEn sampled at edge N gives RdData/RdData_Valid valid after edge N until edge N+1.
- Write latency 1: storage and Cfg_Out update at edge N.
- Cfg_Updated[i] rises at the same edge Cfg_Out changes and clears at N+1.
- Back-to-back reads every cycle keep RdData_Valid high continuously.
- Reset asserted mid-operation: all pulses clear at once and storage reverts to RST_VALS. No pending operation completes.
- After reset deassertion, the first sampled request is handled at the next edge.

## Test plan
- Reset, then read addresses 0..3 -> RdData 00, 00, 81, 20, each with RdData_Valid pulse and RdErr=0.
- Write addr 5 = 0xA5, then read addr 5 next cycle -> RdData=0xA5 one cycle after RdEn.
- Simultaneous WrEn+RdEn at addr 1, data 0x3C -> same cycle RdData=0x3C, Cfg_Updated=4'b0010, Cfg_Out[15:8]=0x3C.
- Repeat write 0x3C to addr 1 -> Cfg_Updated stays 0.
- RO_MASK bit 2 set, write 0xFF to addr 2 -> WrErr pulse, read returns 0x81, no Cfg_Updated.
- DEPTH=12, read addr 14 -> RdData=0, RdErr and RdData_Valid pulse. Write addr 13 -> WrErr pulse.
- Back-to-back reads 0..15, then RST low mid-burst -> outputs clear asynchronously and register 3 reads 0x20 after release.
